// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//   Output-side collector for the NxN output-stationary systolic array.
//   After a start pulse it waits LAT cycles for the PE sums to settle. It then
//   snapshots all N*N sums and pulses pe_clr to clear the accumulators. The
//   results are streamed out row-major, one element per valid/ready beat.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   start        pulse: operand feed for a new product begins this cycle
//   sums_in      PE sums, element (r,c) at [(r*N+c)*SUM_W +: SUM_W]
//   busy         high from accepted start until the last beat is accepted
//   pe_clr       one-cycle pulse, the cycle after capture
//   out_valid    stream data valid
//   out_ready    downstream accepts the beat
//   out_data     current result element
//   out_idx      element index r*N+c of out_data
//   packed_out   snapshot of all sums, same layout as sums_in
//   done         one-cycle pulse after the final beat is accepted
module systolic_result_drain #(
    parameter int N     = 3,
    parameter int SUM_W = 8,
    parameter int LAT   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N*N*SUM_W-1:0]     sums_in,
    output logic                     busy,
    output logic                     pe_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SUM_W-1:0]         out_data,
    output logic [$clog2(N*N)-1:0]   out_idx,
    output logic [N*N*SUM_W-1:0]     packed_out,
    output logic                     done
);

    localparam int NUM   = N * N;
    localparam int IDX_W = $clog2(NUM);
    localparam int CNT_W = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_busy;
    logic                   r_pe_clr;
    logic                   r_valid;
    logic                   r_done;
    logic [NUM*SUM_W-1:0]   r_snap;
    logic [SUM_W-1:0]       w_elem;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_beat;
    logic                   w_last;

    // Next-state and per-cycle event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter is 0 on the first WAIT edge, so hitting LAT-1
                // lands the capture LAT edges after the accepting edge.
                if (r_cnt == CNT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    w_beat = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_pe_clr <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_snap   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pe_clr <= w_capture;
            r_done   <= w_last;

            if (w_accept) begin
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_state == S_WAIT && !w_capture) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_capture) begin
                r_snap  <= sums_in;
                r_idx   <= '0;
                r_valid <= 1'b1;
            end else if (w_last) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_idx   <= '0;
            end else if (w_beat) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Element select from the snapshot; the snapshot doubles as packed_out.
    always_comb begin
        w_elem = '0;
        for (int unsigned k = 0; k < NUM; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_elem = r_snap[k*SUM_W +: SUM_W];
            end
        end
    end

    assign busy       = r_busy;
    assign pe_clr     = r_pe_clr;
    assign out_valid  = r_valid;
    assign out_data   = w_elem;
    assign out_idx    = r_idx;
    assign packed_out = r_snap;
    assign done       = r_done;

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Output-side collector for the 3x3 output-stationary systolic multiplier array. The feed logic skews operands into the array; this block snapshots the nine PE accumulators once the computation has settled, then clears the PEs. It streams the results out one element per beat, row-major, over a valid/ready interface, and also presents them as one packed word.

Parameters:
N, 3, array dimension; N*N results per matrix product
SUM_W, 8, width of each PE sum_out
LAT, 8, cycles from accepted start to the cycle in which all PE sums are final (legal range 1..255)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  pulse: operand feed for a new product begins this cycle
sums_in  input  N*N*SUM_W  PE sums; element (r,c) at bits [(r*N+c)*SUM_W +: SUM_W]
busy  output  1  high from accepted start until the last beat is accepted
pe_clr  output  1  one-cycle pulse that clears the PE accumulators
out_valid  output  1  stream data valid
out_ready  input  1  downstream accepts the beat
out_data  output  SUM_W  current result element
out_idx  output  $clog2(N*N)  element index r*N+c of out_data
packed_out  output  N*N*SUM_W  snapshot of all sums, same layout as sums_in
done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset: state=IDLE. busy, pe_clr, out_valid, done, out_idx, out_data, packed_out, and the wait counter are all 0. rst wins over every other input in the same cycle.
- States: IDLE, WAIT, DRAIN.
- IDLE: start=1 -> WAIT, counter<=0, busy<=1. start=0 -> stay.
- WAIT: counter increments each cycle. The counter increments regardless of out_ready.
- Leaving WAIT: when the counter reaches LAT-1, that edge samples sums_in into the snapshot buffer and packed_out, pulses pe_clr for the next cycle, and moves to DRAIN with out_idx=0 and out_valid=1.
- Capture timing: sums_in is sampled at the edge LAT cycles after the edge that accepted start. For LAT=1, capture occurs on the edge immediately after acceptance.
- DRAIN, data: out_valid=1 and out_data=buffer[out_idx].
  - While out_valid && !out_ready, out_data and out_idx hold stable.
  - On out_valid && out_ready with out_idx < N*N-1, out_idx increments.
- DRAIN, last beat: on the handshake with out_idx == N*N-1:
  - state -> IDLE; out_valid<=0, busy<=0, out_idx<=0;
  - done pulses 1 for the next cycle.
- packed_out holds its value until the next capture. It is not cleared on return to IDLE.
- pe_clr is exactly one cycle per product, asserted the cycle after capture. It is never asserted outside that cycle.
- Ignored inputs:
  - start while busy (WAIT or DRAIN) is ignored and not queued.
  - out_ready outside DRAIN has no effect.
- Back-to-back: start may be accepted in the same cycle done is high, since state is already IDLE then.
- Reset mid-operation: returns to IDLE in one cycle. Any partially drained data is discarded and no done is issued. pe_clr is not pulsed by reset; the PEs have their own rst.
- No arithmetic is performed on sums; SUM_W bits pass through unchanged.

Test Plan:
1. Basic product, LAT=8, N=3, out_ready held 1:
   - stimulus: start at cycle 0; sums_in = element k holds value k+1 (1..9) from cycle 7 on.
   - required: capture at edge 8; pe_clr high in cycle 9; out_valid high cycles 9..17 with out_data 1..9 and out_idx 0..8; done high in cycle 18; busy low from cycle 18.
2. Backpressure:
   - stimulus: as test 1, with out_ready=0 for 3 cycles at out_idx=4.
   - required: out_data=5 and out_idx=4 held stable for those cycles; the sequence then resumes 6..9; done arrives 3 cycles later than in test 1 (cycle 21).
3. Ignored start:
   - stimulus: start pulses during WAIT and again during DRAIN.
   - required: no restart, busy stays 1, output identical to test 1, exactly one pe_clr pulse.
4. Back-to-back:
   - stimulus: second start in the done cycle; new sums 9..1 presented.
   - required: second capture 8 edges later; out_data streams 9..1; packed_out switches to the new snapshot only at the second capture.
5. Reset mid-drain:
   - stimulus: rst in cycle 12 (out_idx=3).
   - required: next cycle out_valid=0, busy=0, out_idx=0, no done pulse; a new start afterwards behaves exactly as test 1.
6. Edge values and LAT=1:
   - stimulus: sums of all 8'hFF and 8'h00 alternating; separately LAT=1 with start at cycle 0.
   - required: the stream reproduces the sums bit-exact; with LAT=1, capture at edge 1 and pe_clr high in cycle 2.
